// File: rtl/bcd_counter_pkg.sv
// Shared types and helpers for the two-digit BCD counter.
package bcd_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

   // Only meaningful once both digits are known to be <= 9.
   function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
      return 7'(tens) * 7'd10 + 7'(ones);
   endfunction

endpackage

// File: rtl/bcd_counter_2digit_if.sv
// Control and display bus of the two-digit BCD counter.
interface bcd_counter_2digit_if;
   logic       start_stop;
   logic       clear;
   logic       up_down;
   logic       load;
   logic [3:0] load_tens;
   logic [3:0] load_ones;
   logic [3:0] bcd_tens_out;
   logic [3:0] bcd_ones_out;
   logic       running;
   logic       carry_out;
   logic       tick_out;

   modport master (
      output start_stop, clear, up_down, load, load_tens, load_ones,
      input  bcd_tens_out, bcd_ones_out, running, carry_out, tick_out
   );

   modport slave (
      input  start_stop, clear, up_down, load, load_tens, load_ones,
      output bcd_tens_out, bcd_ones_out, running, carry_out, tick_out
   );
endinterface

// File: rtl/bcd_counter_2digit_tick_divider.sv
// Prescaler: counts 0..DIV-1 while enabled, tick on the terminal count.
module tick_divider #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic sync_clr,
   output logic tick
);
   localparam int CW = $clog2(DIV);

   logic [CW-1:0] cnt;

   assign tick = enable && (cnt == CW'(DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (sync_clr)
         cnt <= '0;
      else if (enable)
         cnt <= tick ? '0 : cnt + CW'(1);
   end
endmodule

// File: rtl/bcd_counter_2digit.sv
// Two-digit BCD counter with run/pause/clear FSM and prescaled tick.
// Optional BCD_AUTO_STOP_EN: hold at the terminal value and pause instead of wrapping.
module bcd_counter_2digit
   import bcd_counter_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 12000000,
   parameter int TICK_HZ     = 1,
   parameter int COUNT_MAX   = 99
) (
   input logic                 clk,
   input logic                 rst,
   bcd_counter_2digit_if.slave bus
);
   localparam int         DIV      = CLK_FREQ_HZ / TICK_HZ;
   localparam logic [3:0] MAX_TENS = 4'(COUNT_MAX / 10);
   localparam logic [3:0] MAX_ONES = 4'(COUNT_MAX % 10);

   state_t     state, state_nxt;
   logic [3:0] tens, ones, tens_nxt, ones_nxt;
   logic       tick, load_ok, do_tick, wrap;
   logic       running_q, carry_q, tick_q;

   assign load_ok = bus.load
                 && (bus.load_tens <= BCD_DIGIT_MAX)
                 && (bus.load_ones <= BCD_DIGIT_MAX)
                 && (bcd_to_bin(bus.load_tens, bus.load_ones) <= 7'(COUNT_MAX));

   // clear and an accepted load both pre-empt a count in the same cycle
   assign do_tick = tick & ~bus.clear & ~load_ok;

   tick_divider #(.DIV(DIV)) u_div (
      .clk      (clk),
      .rst      (rst),
      .enable   (state == ST_RUN),
      .sync_clr (bus.clear | load_ok),
      .tick     (tick)
   );

   always_comb begin
      state_nxt = (state == ST_RUN || state == ST_PAUSE) ? state : ST_IDLE;
      if (bus.clear) begin
         state_nxt = ST_IDLE;
      end else begin
         if (load_ok && state == ST_IDLE)
            state_nxt = ST_PAUSE;
         if (bus.start_stop)
            state_nxt = (state == ST_RUN) ? ST_PAUSE : ST_RUN;
`ifdef BCD_AUTO_STOP_EN
         else if (do_tick && wrap)
            state_nxt = ST_PAUSE;
`endif
      end
   end

   always_comb begin
      tens_nxt = tens;
      ones_nxt = ones;
      wrap     = 1'b0;
      if (bus.up_down) begin
         if (tens == MAX_TENS && ones == MAX_ONES) begin
            wrap = 1'b1;
`ifndef BCD_AUTO_STOP_EN
            tens_nxt = 4'd0;
            ones_nxt = 4'd0;
`endif
         end else if (ones == BCD_DIGIT_MAX) begin
            ones_nxt = 4'd0;
            tens_nxt = tens + 4'd1;
         end else begin
            ones_nxt = ones + 4'd1;
         end
      end else begin
         if (tens == 4'd0 && ones == 4'd0) begin
            wrap = 1'b1;
`ifndef BCD_AUTO_STOP_EN
            tens_nxt = MAX_TENS;
            ones_nxt = MAX_ONES;
`endif
         end else if (ones == 4'd0) begin
            ones_nxt = BCD_DIGIT_MAX;
            tens_nxt = tens - 4'd1;
         end else begin
            ones_nxt = ones - 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         tens      <= 4'd0;
         ones      <= 4'd0;
         running_q <= 1'b0;
         carry_q   <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         running_q <= (state_nxt == ST_RUN);
         tick_q    <= do_tick;
         carry_q   <= do_tick & wrap;
         if (bus.clear) begin
            tens <= 4'd0;
            ones <= 4'd0;
         end else if (load_ok) begin
            tens <= bus.load_tens;
            ones <= bus.load_ones;
         end else if (do_tick) begin
            tens <= tens_nxt;
            ones <= ones_nxt;
         end
      end
   end

   assign bus.bcd_tens_out = tens;
   assign bus.bcd_ones_out = ones;
   assign bus.running      = running_q;
   assign bus.carry_out    = carry_q;
   assign bus.tick_out     = tick_q;
endmodule

// File: tb/tb_bcd_counter_2digit.sv
// Scoreboard bench: two counters (COUNT_MAX 99 and 59), DIV=10.
module tb_bcd_counter_2digit;
   typedef struct packed {
      logic [7:0] val;
      logic       carry;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]      rst, ss, clr, ud, ld;
   logic [1:0][3:0] lt, lo;

   int   checks = 0;
   int   failures = 0;
   exp_t q0[$];
   exp_t q1[$];

   bcd_counter_2digit_if ia ();
   bcd_counter_2digit_if ib ();

   assign ia.start_stop = ss[0];
   assign ia.clear      = clr[0];
   assign ia.up_down    = ud[0];
   assign ia.load       = ld[0];
   assign ia.load_tens  = lt[0];
   assign ia.load_ones  = lo[0];
   assign ib.start_stop = ss[1];
   assign ib.clear      = clr[1];
   assign ib.up_down    = ud[1];
   assign ib.load       = ld[1];
   assign ib.load_tens  = lt[1];
   assign ib.load_ones  = lo[1];

   bcd_counter_2digit #(.CLK_FREQ_HZ(10), .TICK_HZ(1), .COUNT_MAX(99)) dut_a (
      .clk(clk), .rst(rst[0]), .bus(ia));
   bcd_counter_2digit #(.CLK_FREQ_HZ(10), .TICK_HZ(1), .COUNT_MAX(59)) dut_b (
      .clk(clk), .rst(rst[1]), .bus(ib));

   function automatic logic [7:0] val(input int d);
      return (d == 0) ? {ia.bcd_tens_out, ia.bcd_ones_out} : {ib.bcd_tens_out, ib.bcd_ones_out};
   endfunction

   function automatic logic runv(input int d);
      return (d == 0) ? ia.running : ib.running;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push(input int d, input logic [7:0] v, input logic c);
      exp_t e;
      e.val = v;
      e.carry = c;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Monitor side: every tick_out must match the next queued expectation.
   task automatic mon(input int d, input logic t, input logic c, input logic [7:0] v);
      exp_t e;
      if (t) begin
         if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_tick dut=%0d actual=%0h required=no tick", d, v);
         end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("tick_value dut=%0d", d), v, e.val);
            chk($sformatf("tick_carry dut=%0d", d), c, e.carry);
            chk($sformatf("bcd_digits dut=%0d", d), (v[7:4] <= 9 && v[3:0] <= 9), 1);
         end
      end else if (c) begin
         chk($sformatf("carry_without_tick dut=%0d", d), c, 0);
      end
   endtask

   always @(negedge clk) begin
      if (!rst[0]) mon(0, ia.tick_out, ia.carry_out, val(0));
      if (!rst[1]) mon(1, ib.tick_out, ib.carry_out, val(1));
   end

   task automatic pulse(input int d, input logic s, input logic c, input logic l,
                        input logic [3:0] t, input logic [3:0] o);
      ss[d] = s; clr[d] = c; ld[d] = l; lt[d] = t; lo[d] = o;
      @(posedge clk); #1;
      ss[d] = 1'b0; clr[d] = 1'b0; ld[d] = 1'b0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 2'b11; ss = '0; clr = '0; ld = '0; lt = '0; lo = '0;
      ud = 2'b01;
      #1;
      chk("reset_value_a", val(0), 8'h00);
      chk("reset_running_a", runv(0), 0);
      chk("reset_carry_a", ia.carry_out, 0);
      chk("reset_tick_a", ia.tick_out, 0);
      chk("reset_value_b", val(1), 8'h00);
      @(posedge clk); @(posedge clk); #1;
      rst = 2'b00;

`ifdef BCD_AUTO_STOP_EN
      push(0, 8'h99, 1'b0);
      push(0, 8'h99, 1'b1);
      pulse(0, 0, 0, 1, 4'd9, 4'd8);
      pulse(0, 1, 0, 0, 4'd0, 4'd0);
      cyc(25);
      chk("autostop_running", runv(0), 0);
      chk("autostop_value", val(0), 8'h99);
      push(0, 8'h99, 1'b1);
      pulse(0, 1, 0, 0, 4'd0, 4'd0);
      cyc(12);
      chk("autostop_repause", runv(0), 0);
      chk("autostop_hold", val(0), 8'h99);
`else
      // A: count up from 00, ten ticks in 100 cycles
      for (int k = 1; k <= 10; k++) push(0, {4'(k / 10), 4'(k % 10)}, 1'b0);
      pulse(0, 1, 0, 0, 4'd0, 4'd0);
      chk("running_after_start", runv(0), 1);
      cyc(100);
      chk("value_after_100", val(0), 8'h10);

      // A: wrap 99 -> 00 with carry
      push(0, 8'h00, 1'b1);
      pulse(0, 0, 0, 1, 4'd9, 4'd9);
      chk("load_99", val(0), 8'h99);
      cyc(12);
      chk("wrap_to_00", val(0), 8'h00);

      // A: pause at 37, resume with leftover prescaler count
      pulse(0, 0, 0, 1, 4'd3, 4'd7);
      chk("load_37", val(0), 8'h37);
      cyc(5);
      pulse(0, 1, 0, 0, 4'd0, 4'd0);
      chk("paused_running", runv(0), 0);
      cyc(50);
      chk("frozen_37", val(0), 8'h37);
      push(0, 8'h38, 1'b0);
      pulse(0, 1, 0, 0, 4'd0, 4'd0);
      chk("resumed_running", runv(0), 1);
      cyc(6);
      chk("resume_38_early", val(0), 8'h38);
      chk("resume_tick_seen", q0.size(), 0);

      // A: clear beats load
      pulse(0, 0, 1, 1, 4'd5, 4'd5);
      chk("clear_value", val(0), 8'h00);
      chk("clear_running", runv(0), 0);

      // A: load in IDLE -> PAUSE, start, then async reset mid-prescaler
      pulse(0, 0, 0, 1, 4'd4, 4'd2);
      chk("idle_load_value", val(0), 8'h42);
      chk("idle_load_paused", runv(0), 0);
      pulse(0, 1, 0, 0, 4'd0, 4'd0);
      cyc(3);
      chk("run_before_rst", runv(0), 1);
      rst[0] = 1'b1;
      #1;
      chk("async_rst_value", val(0), 8'h00);
      chk("async_rst_running", runv(0), 0);

      // B (max 59): down from 00 wraps to 59 with carry, then 58
      push(1, 8'h59, 1'b1);
      push(1, 8'h58, 1'b0);
      pulse(1, 1, 0, 0, 4'd0, 4'd0);
      cyc(21);
      pulse(1, 1, 0, 0, 4'd0, 4'd0);
      chk("b_paused", runv(1), 0);
      chk("b_value_58", val(1), 8'h58);
      pulse(1, 0, 0, 1, 4'd6, 4'd0);
      chk("b_load_60_ignored", val(1), 8'h58);
      pulse(1, 0, 0, 1, 4'd4, 4'd10);
      chk("b_load_4A_ignored", val(1), 8'h58);

      // B: borrow 30 -> 29
      push(1, 8'h29, 1'b0);
      pulse(1, 0, 0, 1, 4'd3, 4'd0);
      chk("b_load_30", val(1), 8'h30);
      pulse(1, 1, 0, 0, 4'd0, 4'd0);
      cyc(12);
      chk("b_borrow_29", val(1), 8'h29);

      // B: direction change mid-run, load 59 while running, wrap up to 00
      ud[1] = 1'b1;
      push(1, 8'h00, 1'b1);
      pulse(1, 0, 0, 1, 4'd5, 4'd9);
      chk("b_load_59", val(1), 8'h59);
      chk("b_load_keeps_run", runv(1), 1);
      cyc(12);
      chk("b_wrap_up_00", val(1), 8'h00);
`endif

      chk("queue_a_drained", q0.size(), 0);
      chk("queue_b_drained", q1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
